// File: rtl/cute_lock_seq_keymux.sv
// Counter-driven key-gating mux: a per-state key selects true_in or decoy_in
// for the protected register, with mismatch accounting for observability.
module cute_lock_seq_keymux #(
    parameter int                           KEY_W      = 3,
    parameter int                           NUM_STATES = 4,
    parameter int                           STATE_W    = $clog2(NUM_STATES),
    parameter logic [NUM_STATES*KEY_W-1:0]  KEY_TABLE  = 12'hBB2,
    parameter int                           CNT_MODE   = 0,
    parameter int                           REG_OUT    = 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               advance,
    input  logic [KEY_W-1:0]   keyinput,
    input  logic               true_in,
    input  logic               decoy_in,
    output logic               locked_out,
    output logic [STATE_W-1:0] state_out,
    output logic               key_ok,
    output logic [7:0]         mismatch_cnt,
    output logic               lock_err
);

    localparam logic [STATE_W-1:0] LAST_IDX = STATE_W'(NUM_STATES - 1);

    logic [STATE_W-1:0] idx;
    logic [KEY_W-1:0]   cur_key;
    logic               sel;

    // The table is always addressed by the binary index, whatever state_out shows.
    assign cur_key = KEY_TABLE[int'(idx)*KEY_W +: KEY_W];
    assign key_ok  = (keyinput == cur_key);

    // NOTE: give every always_comb output a default first so no path leaves it unassigned (no latch).
    always_comb begin
        sel = decoy_in;
        if (key_ok) begin
            sel = true_in;
        end
    end

    // Accounting uses the pre-edge idx, i.e. the state being left.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            idx          <= '0;
            mismatch_cnt <= '0;
            lock_err     <= 1'b0;
        end else if (advance) begin
            idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
            if (!key_ok) begin
                if (mismatch_cnt != 8'hFF) begin
                    mismatch_cnt <= mismatch_cnt + 8'd1;
                end
                lock_err <= 1'b1;
            end
        end
    end

    if (CNT_MODE == 1) begin : g_gray
        assign state_out = idx ^ (idx >> 1);
    end else begin : g_bin
        assign state_out = idx;
    end

    if (REG_OUT == 1) begin : g_reg_out
        logic locked_q;
        always_ff @(posedge clock) begin
            if (reset) begin
                locked_q <= 1'b0;
            end else begin
                locked_q <= sel;
            end
        end
        assign locked_out = locked_q;
    end else begin : g_comb_out
        assign locked_out = sel;
    end

endmodule

// File: tb/tb_cute_lock_seq_keymux.sv
// Bench for cute_lock_seq_keymux: default, 8-state Gray and combinational-output
// instances share stimulus; a behavioural model is compared every cycle.
module tb_cute_lock_seq_keymux;

    logic       clock = 1'b0;
    logic       reset;
    logic       advance;
    logic [2:0] keyinput;
    logic       true_in;
    logic       decoy_in;

    logic       lo_a, ok_a, err_a;
    logic [1:0] st_a;
    logic [7:0] cnt_a;
    logic       lo_g, ok_g, err_g;
    logic [2:0] st_g;
    logic [7:0] cnt_g;
    logic       lo_c, ok_c, err_c;
    logic [1:0] st_c;
    logic [7:0] cnt_c;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    cute_lock_seq_keymux dut (
        .clock(clock), .reset(reset), .advance(advance), .keyinput(keyinput),
        .true_in(true_in), .decoy_in(decoy_in), .locked_out(lo_a), .state_out(st_a),
        .key_ok(ok_a), .mismatch_cnt(cnt_a), .lock_err(err_a)
    );

    cute_lock_seq_keymux #(
        .KEY_W(3), .NUM_STATES(8), .KEY_TABLE(24'h1F58D1), .CNT_MODE(1), .REG_OUT(1)
    ) dut_gray (
        .clock(clock), .reset(reset), .advance(advance), .keyinput(keyinput),
        .true_in(true_in), .decoy_in(decoy_in), .locked_out(lo_g), .state_out(st_g),
        .key_ok(ok_g), .mismatch_cnt(cnt_g), .lock_err(err_g)
    );

    cute_lock_seq_keymux #(.REG_OUT(0)) dut_comb (
        .clock(clock), .reset(reset), .advance(advance), .keyinput(keyinput),
        .true_in(true_in), .decoy_in(decoy_in), .locked_out(lo_c), .state_out(st_c),
        .key_ok(ok_c), .mismatch_cnt(cnt_c), .lock_err(err_c)
    );

    // Behavioural model: key tables as plain arrays, counters as integers.
    int keys4 [4]    = '{2, 6, 6, 5};
    int keys8 [8]    = '{1, 2, 3, 4, 5, 6, 7, 0};
    int gray8 [8]    = '{0, 1, 3, 2, 6, 7, 5, 4};
    int m_idx = 0, m_cnt = 0, g_idx = 0, g_cnt = 0;
    bit m_err = 0, m_lo = 0, g_err = 0, g_lo = 0;
    bit model_on = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
        #1;
    endtask

    always @(posedge clock) begin
        bit ok4, ok8;
        ok4 = (int'(keyinput) == keys4[m_idx]);
        ok8 = (int'(keyinput) == keys8[g_idx]);
        if (reset) begin
            m_idx = 0; m_cnt = 0; m_err = 0; m_lo = 0;
            g_idx = 0; g_cnt = 0; g_err = 0; g_lo = 0;
            model_on = 1;
        end else begin
            m_lo = ok4 ? true_in : decoy_in;
            g_lo = ok8 ? true_in : decoy_in;
            if (advance) begin
                if (!ok4) begin
                    m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
                    m_err = 1;
                end
                if (!ok8) begin
                    g_cnt = (g_cnt < 255) ? g_cnt + 1 : 255;
                    g_err = 1;
                end
                m_idx = (m_idx + 1) % 4;
                g_idx = (g_idx + 1) % 8;
            end
        end
    end

    always @(negedge clock) begin
        if (model_on) begin
            bit ok4, ok8;
            ok4 = (int'(keyinput) == keys4[m_idx]);
            ok8 = (int'(keyinput) == keys8[g_idx]);
            check("a_state",  32'(st_a),  32'(m_idx));
            check("a_key_ok", 32'(ok_a),  32'(ok4));
            check("a_locked", 32'(lo_a),  32'(m_lo));
            check("a_cnt",    32'(cnt_a), 32'(m_cnt));
            check("a_err",    32'(err_a), 32'(m_err));
            check("g_state",  32'(st_g),  32'(gray8[g_idx]));
            check("g_key_ok", 32'(ok_g),  32'(ok8));
            check("g_locked", 32'(lo_g),  32'(g_lo));
            check("g_cnt",    32'(cnt_g), 32'(g_cnt));
            check("g_err",    32'(err_g), 32'(g_err));
            check("c_state",  32'(st_c),  32'(m_idx));
            check("c_locked", 32'(lo_c),  32'(ok4 ? true_in : decoy_in));
            check("c_cnt",    32'(cnt_c), 32'(m_cnt));
            check("c_err",    32'(err_c), 32'(m_err));
        end
    end

    initial begin
        int exp_ok [4]    = '{0, 1, 1, 0};
        int gray_seq [9]  = '{0, 1, 3, 2, 6, 7, 5, 4, 0};

        reset = 1'b1; advance = 1'b0; keyinput = 3'd2; true_in = 1'b1; decoy_in = 1'b0;
        tick();
        tick();
        check("rst_state",  32'(st_a),  0);
        check("rst_cnt",    32'(cnt_a), 0);
        check("rst_err",    32'(err_a), 0);
        check("rst_locked", 32'(lo_a),  0);
        check("rst_key_ok", 32'(ok_a),  1);
        check("rst_gray",   32'(st_g),  0);
        reset = 1'b0;

        // Correct key in every state.
        advance = 1'b1;
        for (int i = 0; i < 8; i++) begin
            keyinput = 3'(keys4[i % 4]);
            tick();
            check("ck_locked", 32'(lo_a), 1);
            check("ck_state",  32'(st_a), 32'((i + 1) % 4));
        end
        check("ck_cnt", 32'(cnt_a), 0);
        check("ck_err", 32'(err_a), 0);

        // Static wrong key 6: matches only states 1 and 2.
        keyinput = 3'd6;
        for (int j = 0; j < 4; j++) begin
            #1;
            check("wk_key_ok", 32'(ok_a), 32'(exp_ok[j]));
            tick();
            check("wk_locked", 32'(lo_a), 32'(exp_ok[j]));
        end
        check("wk_cnt", 32'(cnt_a), 2);
        check("wk_err", 32'(err_a), 1);

        // Reach idx 2 (one more mismatch at idx 0), then stall there.
        tick();
        tick();
        keyinput = 3'd0;
        advance  = 1'b0;
        for (int j = 0; j < 5; j++) begin
            decoy_in = (j % 2 == 1);
            tick();
            check("st_state",  32'(st_a),  2);
            check("st_cnt",    32'(cnt_a), 3);
            check("st_locked", 32'(lo_a),  32'(j % 2));
        end
        decoy_in = 1'b0;

        // Gray sequence on the 8-state instance.
        reset = 1'b1;
        tick();
        reset   = 1'b0;
        advance = 1'b1;
        for (int j = 0; j < 8; j++) begin
            tick();
            check("gray_seq", 32'(st_g), 32'(gray_seq[j + 1]));
        end

        // Saturation of the mismatch counter.
        reset = 1'b1;
        tick();
        reset    = 1'b0;
        keyinput = 3'd7;
        for (int k = 1; k <= 300; k++) begin
            tick();
            if (k == 254) check("sat_254", 32'(cnt_a), 254);
            if (k == 255) check("sat_255", 32'(cnt_a), 255);
            if (k == 300) check("sat_hold", 32'(cnt_a), 255);
        end
        check("sat_err", 32'(err_a), 1);

        // Reset at idx 3 with advance on the same edge.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        tick();
        tick();
        check("ri_pre_state", 32'(st_a),  3);
        check("ri_pre_cnt",   32'(cnt_a), 3);
        reset = 1'b1; true_in = 1'b1; decoy_in = 1'b1;
        tick();
        check("ri_state",  32'(st_a),  0);
        check("ri_cnt",    32'(cnt_a), 0);
        check("ri_err",    32'(err_a), 0);
        check("ri_locked", 32'(lo_a),  0);
        reset   = 1'b0;
        advance = 1'b0;

        // Combinational output follows inputs within the cycle.
        keyinput = 3'd2; true_in = 1'b1; decoy_in = 1'b0;
        #1 check("comb_true1",  32'(lo_c), 1);
        true_in = 1'b0;
        #1 check("comb_true0",  32'(lo_c), 0);
        true_in = 1'b1;
        #1 check("comb_true1b", 32'(lo_c), 1);
        keyinput = 3'd7; true_in = 1'b0; decoy_in = 1'b1;
        #1 check("comb_decoy1", 32'(lo_c), 1);
        decoy_in = 1'b0;
        #1 check("comb_decoy0", 32'(lo_c), 0);

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
